alu_rr_arbiter: RTL and testbench

- Shares one 8-bit ALU datapath (AND/OR/NOR/XOR/NAND/XNOR/ADD/SUB) between two independent requesters.
- Round-robin arbitration, valid/ready handshake on each request port, single registered response channel tagged with requester ID and backpressured by the consumer.
- Sits between the two issuing units and the shared ALU; result, carry and zero flags are registered before return.

---
 rtl/alu_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared 8-op ALU with a single
// registered, backpressured response channel tagged by requester ID.
module alu_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_carry,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             last_grant_r;
    logic             id_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             grant_s;
    logic [WIDTH:0]   alu_res_s;

    // Returns {carry, result}; carry is no-borrow for SUB and 0 for logic ops.
    function automatic logic [WIDTH:0] alu_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        case (op)
            3'd0:    alu_f = {1'b0, a & b};
            3'd1:    alu_f = {1'b0, a | b};
            3'd2:    alu_f = {1'b0, ~(a | b)};
            3'd3:    alu_f = {1'b0, a ^ b};
            3'd4:    alu_f = {1'b0, a} + {1'b0, b};
            3'd5:    alu_f = {~diff[WIDTH], diff[WIDTH-1:0]};
            3'd6:    alu_f = {1'b0, ~(a & b)};
            3'd7:    alu_f = {1'b0, ~(a ^ b)};
            default: alu_f = {(WIDTH+1){1'b0}};
        endcase
    endfunction

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Ready is only offered in IDLE, and only to the granted requester.
    always_comb begin
        req0_ready = (state_r == IDLE) && !grant_s && req0_valid;
        req1_ready = (state_r == IDLE) &&  grant_s && req1_valid;
    end

    // ALU evaluates the operands captured at the handshake edge.
    always_comb begin
        alu_res_s = alu_f(op_r, a_r, b_r);
    end

    // Control FSM, operand capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            op_r         <= 3'd0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_z        <= {WIDTH{1'b0}};
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_r         <= grant_s ? req1_op : req0_op;
                        a_r          <= grant_s ? req1_a  : req0_a;
                        b_r          <= grant_s ? req1_b  : req0_b;
                        id_r         <= grant_s;
                        last_grant_r <= grant_s;
                        state_r      <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_z     <= alu_res_s[WIDTH-1:0];
                    rsp_carry <= alu_res_s[WIDTH];
                    rsp_zero  <= (alu_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed cases plus randomized
// arbitration traffic checked against a behavioural model.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
    logic [7:0] rsp_z;

    int checks   = 0;
    int failures = 0;
    int m_last   = 1;

    alu_rr_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the opcode table using plain integer arithmetic.
    function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
        int z;
        int c;
        c = 0;
        case (op)
            0: z = a & b;
            1: z = a | b;
            2: z = (~(a | b)) & 255;
            3: z = a ^ b;
            4: begin z = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            5: begin z = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
            6: z = (~(a & b)) & 255;
            default: z = (~(a ^ b)) & 255;
        endcase
        return 9'(c * 256 + z);
    endfunction

    task automatic check_rsp(input string tag, input int id, input int op, input int a, input int b);
        logic [8:0] e;
        e = ref_alu(op, a, b);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_id"},    rsp_id, id);
        check({tag, "_z"},     rsp_z, e[7:0]);
        check({tag, "_carry"}, rsp_carry, e[8]);
        check({tag, "_zero"},  rsp_zero, (e[7:0] == 8'd0) ? 1 : 0);
    endtask

    task automatic scramble();
        req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        m_last = 1;
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_z", rsp_z, 0);
        check("rst_carry", rsp_carry, 0);
        check("rst_zero", rsp_zero, 0);
    endtask

    // One arbitration round from IDLE with the current operands; stall = cycles of backpressure.
    task automatic arb_op(input logic v0, input logic v1, input int stall);
        int w, op, a, b;
        req0_valid = v0; req1_valid = v1;
        #1;
        if (!v0 && !v1) begin
            check("idle_ready0", req0_ready, 0);
            check("idle_ready1", req1_ready, 0);
            tick();
            check("idle_rsp_valid", rsp_valid, 0);
            return;
        end
        w  = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
        op = w ? req1_op : req0_op;
        a  = w ? req1_a  : req0_a;
        b  = w ? req1_b  : req0_b;
        check("grant_ready0", req0_ready, (w == 0) ? 1 : 0);
        check("grant_ready1", req1_ready, (w == 1) ? 1 : 0);
        tick();
        m_last = w;
        req0_valid = 1'b0; req1_valid = 1'b0;
        scramble();
        check("exec_rsp_valid", rsp_valid, 0);
        tick();
        check_rsp("resp", w, op, a, b);
        if (stall > 0) begin
            rsp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                tick();
                check_rsp("stall", w, op, a, b);
                check("stall_ready0", req0_ready, 0);
                check("stall_ready1", req1_ready, 0);
            end
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        end
        tick();
        check("consume_valid", rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        scramble();
        tick();
        do_reset();

        // Directed cases
        req0_op = 3'd4; req0_a = 8'hF0; req0_b = 8'h20;
        arb_op(1'b1, 1'b0, 0);
        check("add_dir_z", ref_alu(4, 'hF0, 'h20), 9'h110);
        req1_op = 3'd2; req1_a = 8'b0001_0010; req1_b = 8'b0100_0101;
        arb_op(1'b0, 1'b1, 0);
        req1_op = 3'd5; req1_a = 8'h05; req1_b = 8'h05;
        arb_op(1'b0, 1'b1, 0);
        req1_op = 3'd5; req1_a = 8'h03; req1_b = 8'h04;
        arb_op(1'b0, 1'b1, 0);
        req0_op = 3'd3; req0_a = 8'hAA; req0_b = 8'h55;
        arb_op(1'b1, 1'b0, 5);

        // Fairness with both requesters continuously valid
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int op, a, b;
            #1;
            op = (k % 2) ? req1_op : req0_op;
            a  = (k % 2) ? req1_a  : req0_a;
            b  = (k % 2) ? req1_b  : req0_b;
            check("fair_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
            check("fair_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            scramble();
            check("fair_exec_ready0", req0_ready, 0);
            check("fair_exec_ready1", req1_ready, 0);
            tick();
            check_rsp("fair", k % 2, op, a, b);
            tick();
            check("fair_consume", rsp_valid, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        m_last = 1;

        // Reset during EXEC
        req0_op = 3'd4; req0_a = 8'h11; req0_b = 8'h22;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        do_reset();
        arb_op(1'b1, 1'b1, 0);

        // Reset during RESP, after requester 0 was the last winner
        req0_op = 3'd1; req0_a = 8'h0F; req0_b = 8'hF0;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("resp_before_rst", rsp_valid, 1);
        do_reset();
        scramble();
        arb_op(1'b1, 1'b1, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            scramble();
            arb_op(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
